// File: rtl/mix_columns_ctrl.sv
// mix_columns_ctrl: AES (Inv)MixColumns over a 128-bit state, one output byte per cycle
// through a single shared GF(2^8) byte engine, with valid/ready handshakes on both sides.
`default_nettype none

module mix_columns_ctrl #(
  parameter bit INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_state,
  input  logic         i_inverse,
  input  logic         i_clear,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_state,
  output logic         o_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t       state_q;
  logic [3:0]   cnt_q;
  logic [127:0] src_q;
  logic [127:0] res_q;
  logic         mode_q;
  logic         ready_q;
  logic         valid_q;
  logic         busy_q;
  logic [7:0]   byte_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input logic inv, input logic [1:0] idx);
    logic [7:0] c;
    case (idx)
      2'd0:    c = inv ? 8'h0E : 8'h02;
      2'd1:    c = inv ? 8'h0B : 8'h03;
      2'd2:    c = inv ? 8'h0D : 8'h01;
      default: c = inv ? 8'h09 : 8'h01;
    endcase
    return c;
  endfunction

  // Output byte (column idx[3:2], row idx[1:0]) of the column mix.
  function automatic logic [7:0] mix_byte(input logic [127:0] s, input logic [3:0] idx,
                                          input logic inv);
    logic [7:0] acc;
    logic [1:0] ci;
    acc = 8'h00;
    for (int k = 0; k < 4; k++) begin
      ci  = 2'(k) - idx[1:0];
      acc = acc ^ gmul(coef(inv, ci), s[{idx[3:2], 2'(k), 3'b000} +: 8]);
    end
    return acc;
  endfunction

  assign byte_d = mix_byte(src_q, cnt_q, mode_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      src_q   <= '0;
      res_q   <= '0;
      mode_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (i_clear) begin
      // Abort keeps the stale result; it is only meaningful while o_valid is high.
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            state_q <= COMPUTE;
            src_q   <= i_state;
            mode_q  <= i_inverse & INV_EN;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        COMPUTE: begin
          res_q[{cnt_q, 3'b000} +: 8] <= byte_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_state = res_q;

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_ctrl.sv
// tb_mix_columns_ctrl: directed vectors for mix_columns_ctrl with INV_EN=1 and INV_EN=0.
`default_nettype none

module tb_mix_columns_ctrl;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         i_valid;
  logic [127:0] i_state;
  logic         i_inverse;
  logic         i_clear;
  logic         i_ready;
  logic         o_ready_a, o_valid_a, o_busy_a;
  logic [127:0] o_state_a;
  logic         o_ready_b, o_valid_b, o_busy_b;
  logic [127:0] o_state_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mix_columns_ctrl #(.INV_EN(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .i_valid(i_valid), .o_ready(o_ready_a),
    .i_state(i_state), .i_inverse(i_inverse), .i_clear(i_clear),
    .o_valid(o_valid_a), .i_ready(i_ready), .o_state(o_state_a), .o_busy(o_busy_a)
  );

  mix_columns_ctrl #(.INV_EN(1'b0)) dut0 (
    .clk(clk), .n_rst(n_rst), .i_valid(i_valid), .o_ready(o_ready_b),
    .i_state(i_state), .i_inverse(i_inverse), .i_clear(i_clear),
    .o_valid(o_valid_b), .i_ready(i_ready), .o_state(o_state_b), .o_busy(o_busy_b)
  );

  typedef struct {
    logic [127:0] s;
    logic         inv;
    logic [127:0] exp1;
    logic [127:0] exp0;
  } vec_t;

  vec_t vt[5];

  // Columns given as {row0,row1,row2,row3}; row r of column c lands in byte 4c+r.
  function automatic logic [127:0] cols(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0]  cc[4];
    logic [127:0] v;
    cc[0] = c0; cc[1] = c1; cc[2] = c2; cc[3] = c3;
    v = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        v[8*(4*c+r) +: 8] = cc[c][31-8*r -: 8];
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_block(input logic [127:0] s, input logic inv);
    @(negedge clk);
    chk("ready_idle", 128'(o_ready_a), 128'd1);
    i_state   = s;
    i_inverse = inv;
    i_valid   = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    chk("busy_compute", 128'(o_busy_a), 128'd1);
    chk("ready_compute", 128'(o_ready_a), 128'd0);
  endtask

  task automatic wait_done(input bit mutate);
    int n;
    n = 0;
    while (!o_valid_a && n < 40) begin
      if (mutate) begin
        i_state   = ~i_state;
        i_inverse = ~i_inverse;
      end
      @(negedge clk);
      n++;
    end
    chk("latency", 128'(n), 128'd16);
  endtask

  task automatic finish_block;
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;
    chk("ready_after_handoff", 128'(o_ready_a), 128'd1);
    chk("valid_after_handoff", 128'(o_valid_a), 128'd0);
    chk("busy_after_handoff", 128'(o_busy_a), 128'd0);
  endtask

  logic [127:0] ones;
  bit           seen;

  initial begin
    ones = cols(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    vt[0] = '{cols(32'hDB135345, 32'h01010101, 32'h01010101, 32'h01010101), 1'b0,
              cols(32'h8E4DA1BC, 32'h01010101, 32'h01010101, 32'h01010101),
              cols(32'h8E4DA1BC, 32'h01010101, 32'h01010101, 32'h01010101)};
    vt[1] = '{cols(32'h8E4DA1BC, 32'h9FDC589D, 32'h01010101, 32'h01010101), 1'b1,
              cols(32'hDB135345, 32'hF20A225C, 32'h01010101, 32'h01010101),
              cols(32'hCD504506, 32'h9F494F1F, 32'h01010101, 32'h01010101)};
    vt[2] = '{cols(32'h01010101, 32'h01010101, 32'hF20A225C, 32'h01010101), 1'b0,
              cols(32'h01010101, 32'h01010101, 32'h9FDC589D, 32'h01010101),
              cols(32'h01010101, 32'h01010101, 32'h9FDC589D, 32'h01010101)};
    vt[3] = '{cols(32'h01010101, 32'h01010101, 32'h01010101, 32'h8E4DA1BC), 1'b1,
              cols(32'h01010101, 32'h01010101, 32'h01010101, 32'hDB135345),
              cols(32'h01010101, 32'h01010101, 32'h01010101, 32'hCD504506)};
    vt[4] = '{128'h0, 1'b1, 128'h0, 128'h0};

    n_rst = 1'b0; i_valid = 1'b0; i_state = '0; i_inverse = 1'b0;
    i_clear = 1'b0; i_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(o_ready_a), 128'd1);
    chk("rst_valid", 128'(o_valid_a), 128'd0);
    chk("rst_busy", 128'(o_busy_a), 128'd0);
    chk("rst_state", o_state_a, 128'h0);
    n_rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      start_block(vt[i].s, vt[i].inv);
      wait_done(1'b0);
      chk($sformatf("vec%0d_inv_en1", i), o_state_a, vt[i].exp1);
      chk($sformatf("vec%0d_valid_inv_en0", i), 128'(o_valid_b), 128'd1);
      chk($sformatf("vec%0d_inv_en0", i), o_state_b, vt[i].exp0);
      finish_block();
    end

    // Backpressure: result held for 10 cycles in DONE.
    start_block(vt[1].s, 1'b1);
    wait_done(1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 128'(o_valid_a), 128'd1);
      chk("bp_ready", 128'(o_ready_a), 128'd0);
      chk("bp_state", o_state_a, vt[1].exp1);
      @(negedge clk);
    end
    finish_block();

    // Inputs toggled every cycle after acceptance.
    start_block(cols(32'hF20A225C, 32'h01010101, 32'h01010101, 32'h01010101), 1'b0);
    wait_done(1'b1);
    chk("mutate_state", o_state_a, cols(32'h9FDC589D, 32'h01010101, 32'h01010101, 32'h01010101));
    finish_block();
    i_state = '0; i_inverse = 1'b0;

    // Clear at counter 7.
    start_block(vt[0].s, 1'b0);
    repeat (7) @(negedge clk);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    chk("clr_ready", 128'(o_ready_a), 128'd1);
    chk("clr_busy", 128'(o_busy_a), 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_valid_a) seen = 1'b1;
      @(negedge clk);
    end
    chk("clr_no_valid", 128'(seen), 128'd0);

    // Asynchronous reset at counter 12.
    start_block(vt[1].s, 1'b1);
    repeat (12) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("arst_valid", 128'(o_valid_a), 128'd0);
    chk("arst_busy", 128'(o_busy_a), 128'd0);
    chk("arst_ready", 128'(o_ready_a), 128'd1);
    chk("arst_state", o_state_a, 128'h0);
    @(negedge clk);
    n_rst = 1'b1;
    start_block(vt[0].s, 1'b0);
    wait_done(1'b0);
    chk("post_rst_state", o_state_a, vt[0].exp1);
    finish_block();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mix_columns_ctrl.md
MIX_COLUMNS_CTRL -- requirements
Module: mix_columns_ctrl

Interface
REQ-001 SHALL have parameter: INV_EN, 1, when 0 i_inverse is ignored and forward MixColumns is always used.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: n_rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: i_valid  input  1  input block offered.
REQ-005 SHALL have port: o_ready  output  1  controller can accept a block.
REQ-006 SHALL have port: i_state  input  128  AES state; byte k = i_state[8k+7:8k]; column c = bytes 4c..4c+3; row r = byte 4c+r.
REQ-007 SHALL have port: i_inverse  input  1  1 = InvMixColumns, sampled on acceptance only.
REQ-008 SHALL have port: i_clear  input  1  synchronous abort to IDLE.
REQ-009 SHALL have port: o_valid  output  1  result available.
REQ-010 SHALL have port: i_ready  input  1  downstream accepts result.
REQ-011 SHALL have port: o_state  output  128  result, same byte mapping as i_state.
REQ-012 SHALL have port: o_busy  output  1  high in COMPUTE or DONE.

Function
REQ-013 SHALL implement FSM states IDLE, COMPUTE, DONE.
REQ-014 IDLE: o_ready=1; on edge with i_valid=1, register i_state into an internal source register, latch mode (i_inverse & INV_EN), clear 4-bit byte counter, go COMPUTE.
REQ-015 COMPUTE: o_ready=0; each cycle compute exactly one output byte at index = counter using one shared byte engine; write it into the result register at that index; increment counter.
REQ-016 Byte engine: out(c,r) = XOR over k=0..3 of gmul(coef[(k-r) mod 4], s(c,k)); forward coef = {02,03,01,01}, inverse coef = {0E,0B,0D,09}.
REQ-017 gmul SHALL be GF(2^8) mod x^8+x^4+x^3+x+1; xtime(b) = (b<<1)[7:0] XOR (b[7] ? 8'h1B : 8'h00); no unconditional reduction.
REQ-018 When counter=15 is written, counter wraps to 0 and FSM goes DONE on the same edge; o_valid asserts exactly 16 edges after the accepting edge.
REQ-019 DONE: o_valid=1, o_state stable; on edge with i_ready=1 go IDLE; o_ready stays 0 during DONE (no accept in the same cycle as result handoff).
REQ-020 Changes on i_state/i_inverse after acceptance SHALL not affect the result.
REQ-021 i_clear=1 in any state: next state IDLE, counter 0, o_valid=0; i_clear has priority over i_valid and i_ready; result register not cleared.
REQ-022 o_state SHALL drive the result register continuously; content valid only while o_valid=1.
REQ-023 Throughput: one block per 18 cycles minimum (1 accept + 16 compute + 1 DONE).

Reset
REQ-024 n_rst=0 SHALL immediately force IDLE, counter 0, o_valid=0, o_busy=0, o_ready=1 after release, source and result registers 128'h0, latched mode 0.
REQ-025 Reset asserted mid-COMPUTE or in DONE SHALL discard the block; the next accepted block SHALL compute correctly.

Verification
REQ-026 Forward: column 0 bytes {DB,13,53,45}, other columns {01,01,01,01}, i_inverse=0 -> after 16 edges o_valid=1, column 0 {8E,4D,A1,BC}, others {01,01,01,01}.
REQ-027 Inverse: column 0 {8E,4D,A1,BC}, column 1 {9F,DC,58,9D}, i_inverse=1, INV_EN=1 -> column 0 {DB,13,53,45}, column 1 {F2,0A,22,5C}; with INV_EN=0 the same stimulus yields the forward result.
REQ-028 Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and o_state held constant, o_ready=0; i_ready=1 -> IDLE next edge, o_ready=1.
REQ-029 Input mutation: toggle i_state/i_inverse every cycle during COMPUTE -> result equals value from accepted block ({F2,0A,22,5C} -> {9F,DC,58,9D}).
REQ-030 Abort/reset: i_clear=1 at counter=7 -> IDLE next edge, o_valid never asserts; n_rst=0 at counter=12 -> outputs reset immediately; a following block produces the correct REQ-026 result.
